// File: rtl/demux1_2_buf.sv
// 1-to-2 registered stream router.
// Each side has its own two-entry buffer with a registered head word.
module demux1_2_buf_side #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [N-1:0] i_d,
  output logic [N-1:0] o_head,
  output logic         o_valid,
  output logic         o_full
);

  logic [N-1:0] r_head;
  logic [N-1:0] r_tail;
  logic [1:0]   r_cnt;
  logic         w_pop;

  assign o_valid = (r_cnt != 2'd0);
  assign o_full  = (r_cnt == 2'd2);
  assign o_head  = r_head;
  assign w_pop   = o_valid && i_pop;

  // Head stays put when the last word pops, so an empty side shows the last word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= 2'd0;
    end else begin
      unique case ({i_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_head <= i_d;
          else               r_tail <= i_d;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          if (r_cnt == 2'd2) r_head <= r_tail;
          r_cnt <= r_cnt - 2'd1;
        end
        2'b11: begin
          r_head <= i_d;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

module demux1_2_buf #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] S,
  input  logic         Ctrl,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] A,
  output logic         a_valid,
  input  logic         a_ready,
  output logic [N-1:0] B,
  output logic         b_valid,
  input  logic         b_ready
);

  logic w_full_a;
  logic w_full_b;
  logic w_push_a;
  logic w_push_b;

  // Full blocks push even with a pop pending: no ready-to-ready path.
  assign in_ready = Ctrl ? !w_full_b : !w_full_a;
  assign w_push_a = in_valid && in_ready && !Ctrl;
  assign w_push_b = in_valid && in_ready && Ctrl;

  demux1_2_buf_side #(.N(N)) u_a (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push_a),
    .i_pop   (a_ready),
    .i_d     (S),
    .o_head  (A),
    .o_valid (a_valid),
    .o_full  (w_full_a)
  );

  demux1_2_buf_side #(.N(N)) u_b (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push_b),
    .i_pop   (b_ready),
    .i_d     (S),
    .o_head  (B),
    .o_valid (b_valid),
    .o_full  (w_full_b)
  );

endmodule
